// File: rtl/result_drain_pkg.sv
// Shared types and constants for the detection result drain.
// Default field widths mirror the integral-image cache geometry
// (10-bit row, 10-bit column) and the 5-bit detector scale index.
package pkg_resultDrain;

  localparam int INTEGRAL_ROW_BITS = 10;
  localparam int INTEGRAL_COL_BITS = 10;
  localparam int SCALE_BITS_DEF    = 5;
  localparam int DATA_W_DEF        = 32;

  typedef enum logic [2:0] {
    S_Idle,
    S_Fetch,
    S_Capture,
    S_Emit,
    S_Done
  } STATES_t;

  // Queue word that closes a frame; it is consumed but never forwarded.
  localparam logic [DATA_W_DEF-1:0] EXIT_MARKER = '1;

  // Field order matches the queue word: x highest, scale lowest.
  typedef struct packed {
    logic [INTEGRAL_ROW_BITS-1:0] x;
    logic [INTEGRAL_COL_BITS-1:0] y;
    logic [SCALE_BITS_DEF-1:0]    scale;
  } result_t;

  // Unpacks a default-width queue word; bits above x are discarded.
  function automatic result_t unpack_result(input logic [DATA_W_DEF-1:0] word);
    return result_t'(word[$bits(result_t)-1:0]);
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Result queue read port plus host-facing result stream.
// master: the drain block. slave: the queue/sink side.
interface result_drain_if
  import pkg_resultDrain::*;
#(
  parameter int X_BITS     = INTEGRAL_ROW_BITS,
  parameter int Y_BITS     = INTEGRAL_COL_BITS,
  parameter int SCALE_BITS = SCALE_BITS_DEF,
  parameter int DATA_W     = DATA_W_DEF
);

  logic                  rq_empty;
  logic                  rq_re;
  logic [DATA_W-1:0]     rq_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [X_BITS-1:0]     out_x;
  logic [Y_BITS-1:0]     out_y;
  logic [SCALE_BITS-1:0] out_scale;

  modport master (
    input  rq_empty, rq_data, out_ready,
    output rq_re, out_valid, out_x, out_y, out_scale
  );

  modport slave (
    output rq_empty, rq_data, out_ready,
    input  rq_re, out_valid, out_x, out_y, out_scale
  );

endinterface

// File: rtl/result_drain.sv
// result_drain: pops packed detection results from the result queue,
// unpacks them into x/y/scale and offers each on a valid/ready stream.
// An all-ones word ends the frame and pulses done.
// Optional macro RESULT_DRAIN_COUNT_EN enables the per-frame result
// counter; without it result_count is tied to zero.
module result_drain
  import pkg_resultDrain::*;
#(
  parameter int X_BITS     = INTEGRAL_ROW_BITS,
  parameter int Y_BITS     = INTEGRAL_COL_BITS,
  parameter int SCALE_BITS = SCALE_BITS_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [15:0]         result_count,
  result_drain_if.master      bus
);

  localparam int FIELD_W = X_BITS + Y_BITS + SCALE_BITS;

  typedef struct packed {
    logic [X_BITS-1:0]     x;
    logic [Y_BITS-1:0]     y;
    logic [SCALE_BITS-1:0] scale;
  } hold_t;

  STATES_t state, state_n;
  hold_t   hold_p1;
  logic    is_marker;

  // The marker is the all-ones word; any other word is a result.
  assign is_marker = &bus.rq_data;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_Idle;
    else         state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n       = state;
    bus.rq_re     = 1'b0;
    bus.out_valid = 1'b0;
    done          = 1'b0;
    case (state)
      S_Idle: begin
        if (start) state_n = S_Fetch;
      end
      S_Fetch: begin
        bus.rq_re = !bus.rq_empty;
        if (!bus.rq_empty) state_n = S_Capture;
      end
      S_Capture: begin
        state_n = is_marker ? S_Done : S_Emit;
      end
      S_Emit: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = S_Fetch;
      end
      S_Done: begin
        done    = 1'b1;
        state_n = S_Idle;
      end
      default: state_n = S_Idle;
    endcase
  end

  assign busy = (state != S_Idle);

  // Stage p1: hold register, loaded the cycle after the queue read so
  // the fields stay stable for as long as the sink stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 hold_p1 <= '0;
    else if (state == S_Capture) hold_p1 <= bus.rq_data[FIELD_W-1:0];
  end

  assign bus.out_x     = hold_p1.x;
  assign bus.out_y     = hold_p1.y;
  assign bus.out_scale = hold_p1.scale;

`ifdef RESULT_DRAIN_COUNT_EN
  // Saturating increment so a runaway frame cannot wrap to a small count.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Per-frame result counter: cleared by an accepted start, held after done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                              result_count <= '0;
    else if (state == S_Idle && start)        result_count <= '0;
    else if (bus.out_valid && bus.out_ready)  result_count <= sat_inc16(result_count);
  end
`else
  assign result_count = '0;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain with X/Y/SCALE = 10/10/5.
// A queue model feeds the read port; expected results are pushed to a
// scoreboard alongside each queue word and popped as beats are accepted.
module tb_result_drain;
  import pkg_resultDrain::*;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int SB = 5;
  localparam int DW = 32;
`ifdef RESULT_DRAIN_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic [SB-1:0] s;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] result_count;

  result_drain_if #(.X_BITS(XB), .Y_BITS(YB), .SCALE_BITS(SB), .DATA_W(DW)) bus ();

  result_drain #(.X_BITS(XB), .Y_BITS(YB), .SCALE_BITS(SB), .DATA_W(DW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .result_count (result_count),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  int          viol    = 0;
  logic [DW-1:0] fifo[$];
  exp_t          exp_q[$];

  // Queue model: data appears on rq_data the cycle after rq_re.
  always @(posedge clk) begin
    if (bus.rq_re && fifo.size() > 0) begin
      bus.rq_data  <= fifo[0];
      bus.rq_empty <= (fifo.size() == 1);
      fifo.delete(0);
    end
  end

  // Protocol watch: a read must never be issued against an empty queue.
  always @(negedge clk) begin
    #1;
    if (resetn && bus.rq_re && bus.rq_empty) viol++;
  end

  function automatic logic [DW-1:0] pack_word(input exp_t e);
    return {7'h2A, e};
  endfunction

  task automatic push_result(input exp_t e);
    fifo.push_back(pack_word(e));
    exp_q.push_back(e);
    bus.rq_empty = 1'b0;
  endtask

  task automatic push_marker();
    fifo.push_back('1);
    bus.rq_empty = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; bus.out_ready = 1'b0;
    bus.rq_empty = 1'b1; bus.rq_data = '0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, bus.rq_re, bus.out_valid} !== 4'b0000)
      $display("FAIL reset_ctrl got %b need 0000", {busy, done, bus.rq_re, bus.out_valid});
    else n_pass++;
    n_total++;
    if ({bus.out_x, bus.out_y, bus.out_scale} !== '0)
      $display("FAIL reset_fields got %h need 0", {bus.out_x, bus.out_y, bus.out_scale});
    else n_pass++;
    n_total++;
    if (result_count !== 16'd0) $display("FAIL reset_count got %0d need 0", result_count);
    else n_pass++;
    resetn = 1'b1;
  endtask

  task automatic test_single();
    exp_t e, g;
    int   beats = 0;
    bit   fin   = 0;
    e.x = 10'd5; e.y = 10'd7; e.s = 5'd3;
    bus.out_ready = 1'b1;
    push_result(e);
    push_marker();
    start_frame();
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        g = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_total++;
        if ({bus.out_x, bus.out_y, bus.out_scale} !== g)
          $display("FAIL single_beat got %0d/%0d/%0d need %0d/%0d/%0d",
                   bus.out_x, bus.out_y, bus.out_scale, g.x, g.y, g.s);
        else n_pass++;
      end
      if (done) fin = 1;
    end
    n_total++;
    if (fin !== 1'b1 || beats != 1) $display("FAIL single_done got done=%0d beats=%0d need 1/1", fin, beats);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({done, busy} !== 2'b00) $display("FAIL single_after got done/busy=%b need 00", {done, busy});
    else n_pass++;
    n_total++;
    if (result_count !== (CNT_EN ? 16'd1 : 16'd0))
      $display("FAIL single_count got %0d need %0d", result_count, CNT_EN ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    exp_t e, g;
    logic [XB+YB+SB-1:0] f0;
    int   bad = 0;
    bit   fin = 0;
    e.x = 10'd1000; e.y = 10'd513; e.s = 5'd31;
    bus.out_ready = 1'b0;
    push_result(e);
    push_marker();
    start_frame();
    for (int c = 0; c < 20 && !bus.out_valid; c++) @(negedge clk);
    f0 = {bus.out_x, bus.out_y, bus.out_scale};
    n_total++;
    if (f0 !== e) $display("FAIL bp_first got %h need %h", f0, e);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.rq_re || {bus.out_x, bus.out_y, bus.out_scale} !== f0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL bp_hold got %0d bad cycles need 0", bad);
    else n_pass++;
    bus.out_ready = 1'b1;
    g = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_total++;
    if ({bus.out_x, bus.out_y, bus.out_scale} !== g)
      $display("FAIL bp_beat got %h need %h", {bus.out_x, bus.out_y, bus.out_scale}, g);
    else n_pass++;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      if (done) fin = 1;
    end
    n_total++;
    if (fin !== 1'b1 || result_count !== (CNT_EN ? 16'd1 : 16'd0))
      $display("FAIL bp_done got done=%0d count=%0d need 1/%0d", fin, result_count, CNT_EN ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_empty_stall();
    int bad = 0;
    int lat = 0;
    bus.out_ready = 1'b1;
    start_frame();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rq_re || !busy) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL stall_idle got %0d bad cycles need 0", bad);
    else n_pass++;
    push_marker();
    #1;
    n_total++;
    if (bus.rq_re !== 1'b1) $display("FAIL stall_read got rq_re=%b need 1", bus.rq_re);
    else n_pass++;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (!done || lat != 2) $display("FAIL stall_done got done=%b lat=%0d need 1/2", done, lat);
    else n_pass++;
    n_total++;
    if (result_count !== 16'd0) $display("FAIL stall_count got %0d need 0", result_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    e.x = 10'd77; e.y = 10'd88; e.s = 5'd9;
    bus.out_ready = 1'b0;
    push_result(e);
    push_marker();
    start_frame();
    for (int c = 0; c < 20 && !bus.out_valid; c++) @(negedge clk);
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL rmid_emit got valid=%b need 1", bus.out_valid);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_total++;
    if ({busy, done, bus.rq_re, bus.out_valid, bus.out_x, bus.out_y, bus.out_scale, result_count} !== '0)
      $display("FAIL rmid_outputs got busy=%b valid=%b x=%0d y=%0d s=%0d cnt=%0d need all 0",
               busy, bus.out_valid, bus.out_x, bus.out_y, bus.out_scale, result_count);
    else n_pass++;
    fifo.delete();
    exp_q.delete();
    bus.rq_empty = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    int   beats = 0, dones = 0, last = -1, gap_bad = 0, cyc = 0;
    bit   fin = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e.x = XB'($urandom); e.y = YB'($urandom); e.s = SB'($urandom);
      push_result(e);
    end
    push_marker();
    start_frame();
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        if (last >= 0 && cyc - last != 3) gap_bad++;
        last = cyc;
        g = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_total++;
        if ({bus.out_x, bus.out_y, bus.out_scale} !== g)
          $display("FAIL burst_beat%0d got %h need %h", beats, {bus.out_x, bus.out_y, bus.out_scale}, g);
        else n_pass++;
      end
      if (done) begin dones++; fin = 1; end
    end
    repeat (4) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_total++;
    if (beats != 8 || dones != 1) $display("FAIL burst_totals got beats=%0d dones=%0d need 8/1", beats, dones);
    else n_pass++;
    n_total++;
    if (gap_bad != 0) $display("FAIL burst_gap got %0d bad gaps need 0", gap_bad);
    else n_pass++;
    n_total++;
    if (result_count !== (CNT_EN ? 16'd8 : 16'd0))
      $display("FAIL burst_count got %0d need %0d", result_count, CNT_EN ? 8 : 0);
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    exp_t e, g;
    bit   fin = 0;
    bus.out_ready = 1'b0;
    e.x = 10'd11; e.y = 10'd22; e.s = 5'd1;  push_result(e);
    e.x = 10'd33; e.y = 10'd44; e.s = 5'd2;  push_result(e);
    push_marker();
    start_frame();
    for (int c = 0; c < 20 && !bus.out_valid; c++) @(negedge clk);
    g = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_total++;
    if ({bus.out_valid, bus.out_x, bus.out_y, bus.out_scale} !== {1'b1, g})
      $display("FAIL ign_beat1 got v=%b %h need 1 %h", bus.out_valid, {bus.out_x, bus.out_y, bus.out_scale}, g);
    else n_pass++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 20 && !bus.out_valid; c++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    n_total++;
    if ({bus.out_valid, busy, bus.out_x, bus.out_y, bus.out_scale} !== {2'b11, g})
      $display("FAIL ign_state got v=%b busy=%b %h need 11 %h", bus.out_valid, busy,
               {bus.out_x, bus.out_y, bus.out_scale}, g);
    else n_pass++;
    n_total++;
    if (result_count !== (CNT_EN ? 16'd1 : 16'd0))
      $display("FAIL ign_count got %0d need %0d", result_count, CNT_EN ? 1 : 0);
    else n_pass++;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      if (done) fin = 1;
    end
    n_total++;
    if (fin !== 1'b1 || result_count !== (CNT_EN ? 16'd2 : 16'd0))
      $display("FAIL ign_done got done=%0d count=%0d need 1/%0d", fin, result_count, CNT_EN ? 2 : 0);
    else n_pass++;
  endtask

  task automatic test_protocol();
    n_total++;
    if (viol != 0) $display("FAIL rq_re_when_empty got %0d cycles need 0", viol);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_empty_stall();
    test_reset_mid();
    test_back_to_back();
    test_ignored_start();
    repeat (2) @(negedge clk);
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
